// File: rtl/data_memory_pkg.sv
// data_memory_pkg: shared constants and types for the data memory controller
package data_memory_pkg;
  localparam int DEF_DATA_WIDTH = 64;
  localparam int DEF_DEPTH = 64;
  localparam int DEF_READ_LATENCY = 2;
  localparam int MAX_DATA_WIDTH = 1024;
  typedef enum logic {INIT, RUN} state_t;
  typedef struct packed {
    logic valid;
    logic error;
    logic [MAX_DATA_WIDTH-1:0] data;
  } resp_t;
endpackage

// File: rtl/dm_resp_pipe.sv
// dm_resp_pipe: fixed-latency shift register carrying response records
module dm_resp_pipe #(
  parameter int WIDTH = 8,
  parameter int LATENCY = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data
);
  logic [WIDTH-1:0] r_stage [LATENCY];
  // advance one stage per cycle; reset flushes every stage
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int k = 0; k < LATENCY; k++) r_stage[k] <= '0;
    end else begin
      r_stage[0] <= i_data;
      for (int k = 1; k < LATENCY; k++) r_stage[k] <= r_stage[k-1];
    end
  end
  assign o_data = r_stage[LATENCY-1];
endmodule

// File: rtl/data_memory_ctrl.sv
// data_memory_ctrl: byte-enabled word memory with clear sweep and fixed-latency responses
module data_memory_ctrl
  import data_memory_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int READ_LATENCY = DEF_READ_LATENCY
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic                    ReqValid,
  output logic                    ReqReady,
  input  logic                    ReqWrite,
  input  logic [63:0]             Address,
  input  logic [DATA_WIDTH-1:0]   WriteData,
  input  logic [DATA_WIDTH/8-1:0] ByteEnable,
  output logic                    RespValid,
  output logic [DATA_WIDTH-1:0]   ReadData,
  output logic                    RespError
);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int ALIGN = $clog2(BYTES);
  localparam int AW = $clog2(DEPTH);
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  state_t r_state, w_state_nxt;
  logic [AW-1:0] r_sweep, w_sweep_nxt, w_idx;
  logic w_last, w_accept, w_bad;
  resp_t w_resp_in, w_resp_out;
  assign ReqReady = (r_state == RUN) && !Reset;
  assign w_accept = ReqValid && ReqReady;
  assign w_idx = Address[ALIGN +: AW];
  assign w_bad = (|Address[ALIGN-1:0]) || (|(Address >> (ALIGN + AW)));
  assign w_last = r_sweep == AW'(DEPTH - 1);
  // sweep advances once per INIT cycle and holds at the last word
  always_comb begin
    w_state_nxt = (r_state == INIT && w_last) ? RUN : r_state;
    w_sweep_nxt = (r_state == INIT && !w_last) ? r_sweep + AW'(1) : r_sweep;
  end
  // FSM state and sweep counter
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state <= INIT;
      r_sweep <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_sweep <= w_sweep_nxt;
    end
  end
  // clear sweep during INIT, byte-masked writes on accept in RUN
  always_ff @(posedge Clock) begin
    if (r_state == INIT) begin
      r_mem[r_sweep] <= '0;
    end else if (w_accept && ReqWrite && !w_bad) begin
      for (int b = 0; b < BYTES; b++)
        if (ByteEnable[b]) r_mem[w_idx][8*b +: 8] <= WriteData[8*b +: 8];
    end
  end
  // response record built at accept; data only for good reads so idle slots stay zero
  always_comb begin
    w_resp_in = '0;
    w_resp_in.valid = w_accept;
    w_resp_in.error = w_accept && w_bad;
    w_resp_in.data = MAX_DATA_WIDTH'((w_accept && !ReqWrite && !w_bad) ? r_mem[w_idx] : '0);
  end
  dm_resp_pipe #(
    .WIDTH($bits(resp_t)),
    .LATENCY(READ_LATENCY)
  ) u_pipe (
    .i_clk(Clock),
    .i_rst(Reset),
    .i_data(w_resp_in),
    .o_data(w_resp_out)
  );
  assign RespValid = w_resp_out.valid && !Reset;
  assign RespError = w_resp_out.error && !Reset;
  assign ReadData = Reset ? '0 : DATA_WIDTH'(w_resp_out.data);
endmodule

// File: tb/tb_data_memory_ctrl.sv
// tb_data_memory_ctrl: scoreboard bench for data_memory_ctrl at three parameter sets
module tb_data_memory_ctrl;
  logic Clock = 0, Reset = 1;
  always #5 Clock = ~Clock;
  int cyc = 0, n_tests = 0, n_fail = 0;
  always @(posedge Clock) cyc <= cyc + 1;
  typedef struct {int cyc; logic err; logic [63:0] data;} exp_t;
  exp_t q0[$], q1[$], q2[$];
  exp_t e0, e1, e2;
  logic v0 = 0, w0 = 0, v1 = 0, w1 = 0;
  logic [63:0] a0 = '0, wd0 = '0, a1 = '0;
  logic [7:0] be0 = '0;
  logic [31:0] wd1 = '0;
  logic [3:0] be1 = '0;
  logic rdy0, rv0, re0, rdy1, rv1, re1, rdy2, rv2, re2;
  logic [63:0] rd0;
  logic [31:0] rd1, rd2;

  data_memory_ctrl u0 (
    .Clock(Clock), .Reset(Reset), .ReqValid(v0), .ReqReady(rdy0), .ReqWrite(w0),
    .Address(a0), .WriteData(wd0), .ByteEnable(be0),
    .RespValid(rv0), .ReadData(rd0), .RespError(re0));
  data_memory_ctrl #(.DATA_WIDTH(32), .DEPTH(64), .READ_LATENCY(1)) u1 (
    .Clock(Clock), .Reset(Reset), .ReqValid(v1), .ReqReady(rdy1), .ReqWrite(w1),
    .Address(a1), .WriteData(wd1), .ByteEnable(be1),
    .RespValid(rv1), .ReadData(rd1), .RespError(re1));
  data_memory_ctrl #(.DATA_WIDTH(32), .DEPTH(64), .READ_LATENCY(4)) u2 (
    .Clock(Clock), .Reset(Reset), .ReqValid(v1), .ReqReady(rdy2), .ReqWrite(w1),
    .Address(a1), .WriteData(wd1), .ByteEnable(be1),
    .RespValid(rv2), .ReadData(rd2), .RespError(re2));

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // monitors: pop expected response whenever a DUT presents one
  always @(negedge Clock) begin
    if (rv0) begin
      if (q0.size() == 0) chk("u0 unexpected resp", 1, 0);
      else begin
        e0 = q0.pop_front();
        chk("u0 latency", cyc, e0.cyc);
        chk("u0 error", re0, e0.err);
        chk("u0 data", rd0, e0.data);
      end
    end else chk("u0 idle outputs", {re0, rd0}, 0);
  end
  always @(negedge Clock) begin
    if (rv1) begin
      if (q1.size() == 0) chk("u1 unexpected resp", 1, 0);
      else begin
        e1 = q1.pop_front();
        chk("u1 latency", cyc, e1.cyc);
        chk("u1 error", re1, e1.err);
        chk("u1 data", rd1, e1.data);
      end
    end else chk("u1 idle outputs", {re1, rd1}, 0);
  end
  always @(negedge Clock) begin
    if (rv2) begin
      if (q2.size() == 0) chk("u2 unexpected resp", 1, 0);
      else begin
        e2 = q2.pop_front();
        chk("u2 latency", cyc, e2.cyc);
        chk("u2 error", re2, e2.err);
        chk("u2 data", rd2, e2.data);
      end
    end else chk("u2 idle outputs", {re2, rd2}, 0);
  end

  task automatic req0(input logic w, input logic [63:0] a, input logic [63:0] wd,
                      input logic [7:0] be, input logic err, input logic [63:0] d, input bit push);
    exp_t e;
    chk("u0 ready at issue", rdy0, 1);
    v0 = 1; w0 = w; a0 = a; wd0 = wd; be0 = be;
    e = '{cyc + 2, err, d};
    if (push) q0.push_back(e);
    @(negedge Clock);
    v0 = 0;
  endtask

  task automatic req1(input logic w, input logic [63:0] a, input logic [31:0] wd,
                      input logic [3:0] be, input logic err, input logic [31:0] d);
    exp_t e;
    chk("u1/u2 ready at issue", {rdy1, rdy2}, 2'b11);
    v1 = 1; w1 = w; a1 = a; wd1 = wd; be1 = be;
    e = '{cyc + 1, err, {32'h0, d}};
    q1.push_back(e);
    e = '{cyc + 4, err, {32'h0, d}};
    q2.push_back(e);
    @(negedge Clock);
    v1 = 0;
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, " ready"}, {rdy0, rdy1, rdy2}, 0);
    chk({nm, " resp"}, {rv0, re0, rd0, rv1, rv2}, 0);
  endtask

  task automatic release_and_wait(input string nm);
    int n0;
    Reset = 0;
    n0 = cyc;
    for (int i = 0; i < 200 && !(rdy0 && rdy1 && rdy2); i++) @(negedge Clock);
    chk({nm, " ready latency"}, cyc - n0, 64);
    chk({nm, " all ready"}, {rdy0, rdy1, rdy2}, 3'b111);
  endtask

  initial begin
    #100000;
    $display("FAIL global timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge Clock);
    chk_reset("por");
    release_and_wait("por");
    for (int i = 0; i < 64; i++) req0(0, 64'(i * 8), '0, '0, 0, '0, 1);
    req0(1, 64'h40, 64'h1122334455667788, 8'h0F, 0, '0, 1);
    req0(0, 64'h40, '0, '0, 0, 64'h0000000055667788, 1);
    req0(0, 64'h43, '0, '0, 1, '0, 1);
    req0(0, 64'h200, '0, '0, 1, '0, 1);
    req0(1, 64'h43, '1, 8'hFF, 1, '0, 1);
    req0(1, 64'h200, '1, 8'hFF, 1, '0, 1);
    req0(1, 64'h8000000000000040, '1, 8'hFF, 1, '0, 1);
    req0(0, 64'h40, '0, '0, 0, 64'h0000000055667788, 1);
    req0(0, 64'h0, '0, '0, 0, '0, 1);
    req0(0, 64'h48, '0, '0, 0, '0, 1);
    req0(1, 64'h08, 64'hAA, 8'hFF, 0, '0, 1);
    req0(0, 64'h08, '0, '0, 0, 64'hAA, 1);
    req0(1, 64'h08, 64'hBB, 8'hFF, 0, '0, 1);
    req0(0, 64'h08, '0, '0, 0, 64'hBB, 1);
    repeat (4) @(negedge Clock);
    req0(1, 64'h10, 64'h5A, 8'hFF, 0, '0, 1);
    repeat (3) @(negedge Clock);
    req0(0, 64'h10, '0, '0, 0, '0, 0);
    Reset = 1;
    repeat (3) @(negedge Clock);
    chk_reset("mid reset");
    release_and_wait("post reset");
    req0(0, 64'h10, '0, '0, 0, '0, 1);
    req0(0, 64'h08, '0, '0, 0, '0, 1);
    req1(1, 64'h40, 32'h11223344, 4'h3, 0, '0);
    req1(0, 64'h40, '0, '0, 0, 32'h00003344);
    req1(1, 64'h44, 32'hAABBCCDD, 4'hC, 0, '0);
    req1(0, 64'h44, '0, '0, 0, 32'hAABB0000);
    req1(0, 64'h42, '0, '0, 1, '0);
    req1(0, 64'h100, '0, '0, 1, '0);
    req1(0, 64'hFC, '0, '0, 0, '0);
    repeat (8) @(negedge Clock);
    chk("u0 queue drained", q0.size(), 0);
    chk("u1 queue drained", q1.size(), 0);
    chk("u2 queue drained", q2.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
